// File: rtl/ofdm_cp_removal_framer.sv
// Cyclic-prefix removal framer: after each detector trigger, drops the CP of every
// OFDM symbol and forwards the FFT_LEN useful samples as one packet per symbol.
module ofdm_cp_removal_framer #(
    parameter logic [7:0] SR_BASE  = 8'd144,
    parameter int         MAX_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tuser,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tuser,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        frame_active,
    output logic [15:0] dropped_triggers
);

    typedef enum logic [1:0] {IDLE, SKIP_CP, PASS} state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_LOG2);

    state_t      state;
    logic [15:0] cp_len, num_syms;
    logic [3:0]  fft_log2;
    logic [15:0] cp_len_s, fft_len_s, num_syms_s;
    logic [15:0] samp_cnt, sym_cnt;
    logic        first_flag;
    logic        beat, trig_beat, last_samp;
    logic        unused_inputs;

    function automatic logic [3:0] clamp_log2(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (v < 4'd3)
            r = 4'd3;
        else if (v > MAX_L)
            r = MAX_L;
        return r;
    endfunction

    // In PASS the stream is a zero-latency wire, so the AXI hold rule is inherited from upstream
    assign i_tready     = (state == PASS) ? o_tready : 1'b1;
    assign beat         = i_tvalid && i_tready;
    assign trig_beat    = beat && i_tuser;
    assign last_samp    = (samp_cnt == fft_len_s - 16'd1);
    assign o_tdata      = i_tdata;
    assign o_tvalid     = (state == PASS) && i_tvalid;
    assign o_tuser      = (state == PASS) && first_flag;
    assign o_tlast      = (state == PASS) && last_samp;
    assign frame_active = (state != IDLE);

    assign unused_inputs = ^{i_tlast, set_data[31:16]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            cp_len           <= 16'd16;
            fft_log2         <= 4'd6;
            num_syms         <= 16'd1;
            cp_len_s         <= 16'd0;
            fft_len_s        <= 16'd0;
            num_syms_s       <= 16'd0;
            samp_cnt         <= 16'd0;
            sym_cnt          <= 16'd0;
            first_flag       <= 1'b0;
            dropped_triggers <= 16'd0;
        end else begin
            if (set_stb) begin
                if (set_addr == SR_BASE)
                    cp_len <= set_data[15:0];
                else if (set_addr == SR_BASE + 8'd1)
                    fft_log2 <= clamp_log2(set_data[3:0]);
                else if (set_addr == SR_BASE + 8'd2)
                    num_syms <= set_data[15:0];
            end

            if (trig_beat && state != IDLE && dropped_triggers != 16'hFFFF)
                dropped_triggers <= dropped_triggers + 16'd1;

            if (clear) begin
                state      <= IDLE;
                samp_cnt   <= 16'd0;
                sym_cnt    <= 16'd0;
                first_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Shadows take the pre-write register values if a write lands on this beat
                        if (trig_beat) begin
                            cp_len_s   <= cp_len;
                            fft_len_s  <= 16'd1 << fft_log2;
                            num_syms_s <= num_syms;
                            samp_cnt   <= 16'd0;
                            sym_cnt    <= 16'd0;
                            first_flag <= 1'b1;
                            state      <= (cp_len != 16'd0) ? SKIP_CP : PASS;
                        end
                    end
                    SKIP_CP: begin
                        if (beat) begin
                            if (samp_cnt == cp_len_s - 16'd1) begin
                                samp_cnt <= 16'd0;
                                state    <= PASS;
                            end else begin
                                samp_cnt <= samp_cnt + 16'd1;
                            end
                        end
                    end
                    PASS: begin
                        if (beat) begin
                            first_flag <= 1'b0;
                            if (last_samp) begin
                                samp_cnt <= 16'd0;
                                sym_cnt  <= sym_cnt + 16'd1;
                                if (num_syms_s != 16'd0 && (sym_cnt + 16'd1) == num_syms_s)
                                    state <= IDLE;
                                else if (cp_len_s != 16'd0)
                                    state <= SKIP_CP;
                            end else begin
                                samp_cnt <= samp_cnt + 16'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
